// File: rtl/bsg_manycore_mem_responder_if.sv
// Request/response bundle between a manycore endpoint (master) and the memory responder (slave).
// Handshake: a request is presented with in_v_i and held stable until in_yumi_o; returning_v_o follows each yumi by one cycle.
interface bsg_manycore_mem_responder_if #(
    parameter int data_width_p  = 32,
    parameter int addr_width_p  = 28,
    parameter int mask_width_lp = data_width_p >> 3
);
    logic                     in_v_i;
    logic                     in_we_i;
    logic [addr_width_p-1:0]  in_addr_i;
    logic [data_width_p-1:0]  in_data_i;
    logic [mask_width_lp-1:0] in_mask_i;
    logic                     in_yumi_o;
    logic                     returning_v_o;
    logic [data_width_p-1:0]  returning_data_o;
    logic                     err_o;
    logic [addr_width_p-1:0]  err_addr_o;
    logic [31:0]              req_count_o;
    logic                     dbg_state_o;

    modport master (
        output in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i,
        input  in_yumi_o, returning_v_o, returning_data_o, err_o, err_addr_o,
               req_count_o, dbg_state_o
    );

    modport slave (
        input  in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i,
        output in_yumi_o, returning_v_o, returning_data_o, err_o, err_addr_o,
               req_count_o, dbg_state_o
    );
endinterface

// File: rtl/bsg_manycore_mem_responder.sv
// Services remote load/store requests against a local synchronous word SRAM;
// partial-mask stores run as a two-cycle read-modify-write.
module bsg_manycore_mem_responder #(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 28,
    parameter int mem_els_p         = 1024,
    parameter int mem_addr_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1,
    parameter int mask_width_lp     = data_width_p >> 3
) (
    input logic clk_i,
    input logic reset_i,
    bsg_manycore_mem_responder_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    state_e state_q;

    logic [data_width_p-1:0] mem [mem_els_p];
    logic [data_width_p-1:0] rdata_q;

    logic                         ret_v_q;
    logic                         ret_load_q;
    logic                         err_q;
    logic [addr_width_p-1:0]      err_addr_q;
    logic [31:0]                  count_q;

    logic                         in_range;
    logic [mem_addr_width_lp-1:0] idx;
    logic                         full_mask;
    logic                         zero_mask;
    logic                         yumi;
    logic                         mem_re;
    logic                         mem_we;
    logic                         go_merge;
    logic                         load_hit;
    logic [data_width_p-1:0]      wdata;
    logic [data_width_p-1:0]      merged;

    assign in_range  = (bus.in_addr_i[addr_width_p-1:mem_addr_width_lp] == '0);
    assign idx       = bus.in_addr_i[mem_addr_width_lp-1:0];
    assign full_mask = &bus.in_mask_i;
    assign zero_mask = ~|bus.in_mask_i;

    // In MERGE the SRAM output holds the old word read in the previous cycle.
    always_comb begin
        merged = rdata_q;
        for (int b = 0; b < mask_width_lp; b++) begin
            if (bus.in_mask_i[b]) merged[8*b +: 8] = bus.in_data_i[8*b +: 8];
        end
    end

    always_comb begin
        yumi     = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        go_merge = 1'b0;
        load_hit = 1'b0;
        wdata    = bus.in_data_i;
        if (bus.in_v_i) begin
            if (state_q == IDLE) begin
                if (!in_range) begin
                    yumi = 1'b1;
                end else if (!bus.in_we_i) begin
                    yumi     = 1'b1;
                    mem_re   = 1'b1;
                    load_hit = 1'b1;
                end else if (full_mask) begin
                    yumi   = 1'b1;
                    mem_we = 1'b1;
                end else if (zero_mask) begin
                    yumi = 1'b1;
                end else begin
                    mem_re   = 1'b1;
                    go_merge = 1'b1;
                end
            end else begin
                yumi   = 1'b1;
                mem_we = 1'b1;
                wdata  = merged;
            end
        end
    end

    // SRAM contents and read register are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[idx] <= wdata;
        if (mem_re) rdata_q <= mem[idx];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ret_v_q    <= 1'b0;
            ret_load_q <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            count_q    <= '0;
        end else begin
            ret_v_q    <= yumi;
            ret_load_q <= load_hit;
            if (go_merge) begin
                state_q <= MERGE;
            end else if (state_q == MERGE && yumi) begin
                state_q <= IDLE;
            end
            if (yumi && !in_range && state_q == IDLE && !err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= bus.in_addr_i;
            end
            if (yumi) count_q <= count_q + 32'd1;
        end
    end

    assign bus.in_yumi_o        = yumi;
    assign bus.returning_v_o    = ret_v_q;
    assign bus.returning_data_o = ret_load_q ? rdata_q : '0;
    assign bus.err_o            = err_q;
    assign bus.err_addr_o       = err_addr_q;
    assign bus.req_count_o      = count_q;
    assign bus.dbg_state_o      = state_q;

endmodule

// File: doc/bsg_manycore_mem_responder.md
# bsg_manycore_mem_responder

Remote-memory responder that sits behind a manycore endpoint's receive side and services incoming load/store requests against a local single-port synchronous word SRAM. It serves as the target end for remote requests issued by vanilla cores: it accepts requests, performs them, and asserts `returning_v_o` exactly one cycle after each accept so the endpoint can build the return packet. Partial-mask stores are executed as a two-cycle read-modify-write. The block also keeps a sticky out-of-range error and a request counter for debug.

## Interface
Parameters:
- `data_width_p`, 32: word width; must be a multiple of 8.
- `addr_width_p`, 28: word-address width of incoming requests.
- `mem_els_p`, 1024: SRAM depth in words; power of two, at least 2.
- `mem_addr_width_lp`, `BSG_SAFE_CLOG2(mem_els_p)`: SRAM index width.
- `mask_width_lp`, `data_width_p>>3`: byte-mask width.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `in_v_i`  in  1  request valid; held stable until `in_yumi_o`.
- `in_we_i`  in  1  1 = store, 0 = load.
- `in_addr_i`  in  `addr_width_p`  word address.
- `in_data_i`  in  `data_width_p`  store data.
- `in_mask_i`  in  `mask_width_lp`  store byte enables; ignored for loads.
- `in_yumi_o`  out  1  request consumed this cycle.
- `returning_v_o`  out  1  response valid, exactly one cycle after `in_yumi_o`.
- `returning_data_o`  out  `data_width_p`  load data; 0 for stores.
- `err_o`  out  1  sticky out-of-range flag.
- `err_addr_o`  out  `addr_width_p`  address of the first out-of-range request.
- `req_count_o`  out  32  count of accepted requests; wraps.

## Operation
- FSM states: IDLE and MERGE. Reset state is IDLE.
- An address is in range when `in_addr_i[addr_width_p-1:mem_addr_width_lp]` is 0. The SRAM index is the low `mem_addr_width_lp` bits.
- IDLE with `in_v_i` high:
  - Load in range: read the SRAM, assert `in_yumi_o`, stay in IDLE.
  - Store in range with all mask bits set: write the full word, assert `in_yumi_o`, stay in IDLE.
  - Store in range with mask 0: no SRAM access, assert `in_yumi_o`, stay in IDLE.
  - Store in range with a partial mask: read the SRAM, deassert `in_yumi_o`, go to MERGE.
  - Out of range, load or store: no SRAM access, assert `in_yumi_o`, stay in IDLE. Load returns 0. If `err_o` is clear, set `err_o` and capture `err_addr_o`; later errors do not update `err_addr_o`.
- MERGE:
  - Per byte: merged = mask ? `in_data_i` byte : SRAM read byte.
  - Write the merged word, assert `in_yumi_o`, return to IDLE.
  - `in_v_i` is guaranteed high and stable in MERGE.
- `req_count_o` increments by 1 on every `in_yumi_o` and wraps from 2^32-1 to 0.
- SRAM contents are not reset.

## Timing
- Reset values: `in_yumi_o`=0, `returning_v_o`=0, `returning_data_o`=0, `err_o`=0, `err_addr_o`=0, `req_count_o`=0, state=IDLE.
- `in_yumi_o` is combinational from `in_v_i`, `in_we_i`, `in_mask_i`, `in_addr_i` and state. It is never asserted while `in_v_i` is low.
- Latency, accept to response:
  - Load, full-mask store, zero-mask store, out-of-range: yumi in cycle N, `returning_v_o` in N+1.
  - Partial-mask store: read in cycle N, yumi in N+1, `returning_v_o` in N+2.
- `returning_data_o` is valid only while `returning_v_o` is high:
  - load in range: SRAM read data;
  - stores and out-of-range loads: 0.
- Throughput is one request per cycle, except a partial-mask store occupies 2 cycles.
- Back-to-back hazard: a load in cycle N+1 to the address written in cycle N returns the new data. A load immediately after a MERGE write also sees the merged word.
- Reset asserted in MERGE: return to IDLE immediately. The pending write is aborted, no yumi or response is issued, and the request stays pending in the endpoint for replay.
- Reset asserted in the cycle after a yumi suppresses that response. The endpoint is reset alongside this block.

## Test plan
- Full-word store then load: store 0xDEADBEEF to addr 5, mask 4'hF, then load addr 5. Yumi occurs on both with no stall. Load response in the next cycle with data 0xDEADBEEF. Store response data is 0.
- Partial store RMW: addr 5 holds 0xDEADBEEF; store 0x11223344 with mask 4'b0101. `in_yumi_o` is low in the first cycle and high in the second, response one cycle later. A load of addr 5 then returns 0xDE22BE44.
- Zero mask and out of range: a store with mask 0 leaves the word unchanged and yields one response. A load from addr 0x400 (mem_els_p=1024) returns 0 and sets `err_o`=1 with `err_addr_o`=0x400. A later out-of-range store to 0x800 leaves `err_addr_o` at 0x400.
- Back-to-back stream: `in_v_i` held high for 8 mixed full-width loads/stores. Yields 8 consecutive yumi cycles, each followed by a response. `req_count_o` equals 8. Read-after-write data is correct.
- Reset in MERGE: assert `reset_i` in the MERGE cycle of a partial store. No yumi and no response occur, the SRAM word is unchanged, and all outputs show their reset values.
- Counter wrap: preload `req_count_o` to 0xFFFFFFFF through forced state or a long run. One more accepted request makes `req_count_o` read 0.
